// File: rtl/sram_pkg.sv
// Shared constants for the SRAM responder slice.
package sram_pkg;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned DATA_W = LANES * LANE_W;
  localparam logic [DATA_W-1:0] RESET_RDATA_DEFAULT = 32'h0;
endpackage

// File: rtl/sram_if.sv
// Request/response bundle between a fetcher and sram_responder.
// SRAM_PERF_EN adds the rd_cnt/wr_cnt access counters.
interface sram_if;
  import sram_pkg::*;

  logic              en;
  logic [LANES-1:0]  wen;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              misalign_err;
`ifdef SRAM_PERF_EN
  logic [31:0]       rd_cnt;
  logic [31:0]       wr_cnt;

  modport master (output en, wen, addr, wdata, input rdata, misalign_err, rd_cnt, wr_cnt);
  modport slave  (input en, wen, addr, wdata, output rdata, misalign_err, rd_cnt, wr_cnt);
`else
  modport master (output en, wen, addr, wdata, input rdata, misalign_err);
  modport slave  (input en, wen, addr, wdata, output rdata, misalign_err);
`endif
endinterface

// File: rtl/sram_array.sv
// Word storage with per-byte-lane write enables and asynchronous read.
module sram_array
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[idx][LANE_W*i +: LANE_W] <= wdata[LANE_W*i +: LANE_W];
    end
  end

  assign rdata_c = mem[idx];
endmodule

// File: rtl/sram_responder.sv
// Single-cycle SRAM responder: address decode, registered rdata, sticky misalign flag.
// SRAM_PERF_EN adds saturating accepted-read/write counters.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [DATA_W-1:0] RESET_RDATA = RESET_RDATA_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  sram_if.slave bus
);
  logic [ADDR_W-1:0] idx_c;
  logic              rd_acc_c;
  logic              wr_acc_c;
  logic [LANES-1:0]  lane_we_c;
  logic [DATA_W-1:0] arr_rdata_c;
  logic [DATA_W-1:0] rdata_q;
  logic              misalign_q;
  logic              unused_addr_hi;

  // Upper address bits alias onto the same words.
  assign idx_c          = bus.addr[ADDR_W+1:2];
  assign unused_addr_hi = &{1'b0, bus.addr[31:ADDR_W+2]};

  assign wr_acc_c  = bus.en && !reset && (bus.wen != '0);
  assign rd_acc_c  = bus.en && !reset && (bus.wen == '0);
  assign lane_we_c = wr_acc_c ? bus.wen : '0;

  sram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we      (lane_we_c),
    .idx     (idx_c),
    .wdata   (bus.wdata),
    .rdata_c (arr_rdata_c)
  );

  // rdata only moves on an accepted read so a stalled fetcher can resample it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q    <= RESET_RDATA;
      misalign_q <= 1'b0;
    end else begin
      if (rd_acc_c) rdata_q <= arr_rdata_c;
      if (bus.en && (bus.addr[1:0] != 2'b00)) misalign_q <= 1'b1;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.misalign_err = misalign_q;

`ifdef SRAM_PERF_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      if (rd_acc_c && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_acc_c && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`endif
endmodule
